// File: rtl/ir_tx_scheduler.sv
//-----------------------------------------------------------------------------
// ir_tx_scheduler
//
// Queues NEC IR frame requests from two requesters and hands them to the IR
// transmitter one at a time. A round-robin arbiter accepts at most one frame
// per cycle into a shared FIFO. An issue FSM pops the head frame, raises
// tx_send and then follows the transmitter's busy flag until the frame ends.
//
// Ports
//   clk, rst_n             system clock, asynchronous active-low reset
//   reqN_valid/addr/cmd    requester N frame offer (N = 0, 1)
//   reqN_ready             frame from requester N accepted this cycle (comb)
//   tx_busy                transmitter busy flag
//   tx_send                send request to transmitter (registered)
//   tx_addr, tx_cmd        frame fields, held stable from issue through ACTIVE
//   fifo_count             number of queued frames
//   err_timeout            one-cycle pulse when a frame is dropped because
//                          tx_busy never rose within BUSY_TIMEOUT cycles
//   sched_state            FSM state (0 IDLE, 1 ISSUE, 2 ACTIVE)
//   rep_hold               (IR_TX_REPEAT_EN only) held-key auto-repeat request
//
// Build option
//   IR_TX_REPEAT_EN        adds rep_hold; when defined, a frame is re-issued
//                          on every tx_busy fall while rep_hold=1 and the FIFO
//                          is empty.
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | no frame in flight; pops the FIFO head when one is queued
// ISSUE | tx_send high, waiting for tx_busy to rise (timer running)
// ACTIVE| transmitter busy with the frame; tx_send low until tx_busy falls
//-----------------------------------------------------------------------------
module ir_tx_scheduler #(
   parameter int FIFO_DEPTH   = 4,
   parameter int BUSY_TIMEOUT = 2048
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req0_valid,
   input  logic [15:0]                   req0_addr,
   input  logic [7:0]                    req0_cmd,
   output logic                          req0_ready,
   input  logic                          req1_valid,
   input  logic [15:0]                   req1_addr,
   input  logic [7:0]                    req1_cmd,
   output logic                          req1_ready,
   input  logic                          tx_busy,
`ifdef IR_TX_REPEAT_EN
   input  logic                          rep_hold,
`endif
   output logic                          tx_send,
   output logic [15:0]                   tx_addr,
   output logic [7:0]                    tx_cmd,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_timeout,
   output logic [1:0]                    sched_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [TW-1:0] TMR_LOAD = TW'(BUSY_TIMEOUT - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   // arbitration
   logic          full;
   logic          grant0;
   logic          grant1;
   logic          push;
   logic [23:0]   push_data;
   logic          rr_q, rr_d;

   // FIFO storage, {addr, cmd} per entry
   logic [23:0]   mem_q [FIFO_DEPTH];
   logic [23:0]   mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop;

   // issue FSM
   logic [1:0]    state_q, state_d;
   logic          send_q, send_d;
   logic [15:0]   addr_q, addr_d;
   logic [7:0]    cmd_q, cmd_d;
   logic          err_q, err_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          repeat_req;

`ifdef IR_TX_REPEAT_EN
   assign repeat_req = rep_hold;
`else
   assign repeat_req = 1'b0;
`endif

   //--------------------------------------------------------------------------
   // Round-robin arbiter. rr_q selects the requester that wins a tie
   // (0 = req0, 1 = req1); after every accepted push it points at the
   // requester that was not served.
   //--------------------------------------------------------------------------
   always_comb begin
      full   = (count_q == FULL_CNT);
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!full) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~rr_q;
            grant1 = rr_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
      push      = grant0 | grant1;
      push_data = grant1 ? {req1_addr, req1_cmd} : {req0_addr, req0_cmd};
      rr_d      = push ? grant0 : rr_q;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   //--------------------------------------------------------------------------
   // Issue FSM and FIFO pointer update. The pop decision looks at the
   // registered count only, so a frame pushed into an empty FIFO is popped on
   // the following edge.
   //--------------------------------------------------------------------------
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      state_d  = state_q;
      send_d   = send_q;
      addr_d   = addr_q;
      cmd_d    = cmd_q;
      err_d    = 1'b0;
      tmr_d    = tmr_q;
      pop      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop             = 1'b1;
               {addr_d, cmd_d} = mem_q[rd_ptr_q];
               send_d          = 1'b1;
               tmr_d           = TMR_LOAD;
               state_d         = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // busy wins over the timeout when both happen in the same cycle
            if (tx_busy) begin
               send_d  = 1'b0;
               state_d = ST_ACTIVE;
            end else if (tmr_q == '0) begin
               send_d  = 1'b0;
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         ST_ACTIVE: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
               // held-key repeat re-sends the frame still in tx_addr/tx_cmd,
               // but only when nothing else is waiting in the FIFO
               if (repeat_req && (count_q == '0)) begin
                  send_d  = 1'b1;
                  tmr_d   = TMR_LOAD;
                  state_d = ST_ISSUE;
               end
            end
         end
         default: begin
            send_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q     <= 1'b0;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_IDLE;
         send_q   <= 1'b0;
         addr_q   <= '0;
         cmd_q    <= '0;
         err_q    <= 1'b0;
         tmr_q    <= '0;
      end else begin
         rr_q     <= rr_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         send_q   <= send_d;
         addr_q   <= addr_d;
         cmd_q    <= cmd_d;
         err_q    <= err_d;
         tmr_q    <= tmr_d;
      end
   end

   assign tx_send     = send_q;
   assign tx_addr     = addr_q;
   assign tx_cmd      = cmd_q;
   assign fifo_count  = count_q;
   assign err_timeout = err_q;
   assign sched_state = state_q;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
//-----------------------------------------------------------------------------
// Bench for ir_tx_scheduler. A small transmitter model answers tx_send with a
// busy pulse of programmable length; a monitor records every tx_send rise.
// Expected frames are queued as they are offered and matched, in order,
// against the recorded issues.
//-----------------------------------------------------------------------------
module tb_ir_tx_scheduler;

   localparam int TIMEOUT = 2048;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  cmd;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid;
   logic [15:0] req0_addr;
   logic [7:0]  req0_cmd;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_addr;
   logic [7:0]  req1_cmd;
   logic        req1_ready;
   logic        tx_busy = 1'b0;
   logic        tx_send;
   logic [15:0] tx_addr;
   logic [7:0]  tx_cmd;
   logic [2:0]  fifo_count;
   logic        err_timeout;
   logic [1:0]  sched_state;
`ifdef IR_TX_REPEAT_EN
   logic        rep_hold;
`endif

   int          total = 0;
   int          bad   = 0;
   frame_t      sb[$];

   // monitor-owned capture of issued frames
   logic [15:0] obs_addr [64];
   logic [7:0]  obs_cmd  [64];
   int          obs_wr    = 0;
   int          err_cnt   = 0;
   logic        prev_send = 1'b0;

   // stimulus-owned
   int          rd_idx = 0;
   int          extra  = 0;
   bit          xmit_en;
   int          busy_len;

   // model-owned
   int          busy_left = 0;

   always #10 clk = ~clk;

   ir_tx_scheduler #(.FIFO_DEPTH(4), .BUSY_TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_addr   (req0_addr),
      .req0_cmd    (req0_cmd),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_addr   (req1_addr),
      .req1_cmd    (req1_cmd),
      .req1_ready  (req1_ready),
      .tx_busy     (tx_busy),
`ifdef IR_TX_REPEAT_EN
      .rep_hold    (rep_hold),
`endif
      .tx_send     (tx_send),
      .tx_addr     (tx_addr),
      .tx_cmd      (tx_cmd),
      .fifo_count  (fifo_count),
      .err_timeout (err_timeout),
      .sched_state (sched_state)
   );

   // transmitter model: busy rises half a cycle after tx_send is seen and
   // stays high for busy_len cycles
   always @(negedge clk) begin
      if (!rst_n) begin
         tx_busy   = 1'b0;
         busy_left = 0;
      end else if (tx_busy) begin
         if (busy_left <= 1) tx_busy = 1'b0;
         else busy_left--;
      end else if (tx_send && xmit_en) begin
         tx_busy   = 1'b1;
         busy_left = busy_len;
      end
   end

   // monitor: record each issue (tx_send rising) and count err pulses
   always @(negedge clk) begin
      if (rst_n && tx_send && !prev_send) begin
         if (obs_wr < 64) begin
            obs_addr[obs_wr] = tx_addr;
            obs_cmd[obs_wr]  = tx_cmd;
         end
         obs_wr++;
      end
      if (rst_n && err_timeout) err_cnt++;
      prev_send = rst_n ? tx_send : 1'b0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic score(input string tag);
      frame_t f;
      while (rd_idx < obs_wr) begin
         if (sb.size() == 0 || rd_idx >= 64) begin
            extra++;
         end else begin
            f = sb.pop_front();
            chk({tag, "_addr"}, obs_addr[rd_idx], f.addr);
            chk({tag, "_cmd"}, obs_cmd[rd_idx], f.cmd);
         end
         rd_idx++;
      end
   endtask

   task automatic push1(input bit which, input logic [15:0] a, input logic [7:0] c,
                        input string tag);
      frame_t f;
      if (which) begin
         req1_valid = 1'b1; req1_addr = a; req1_cmd = c;
      end else begin
         req0_valid = 1'b1; req0_addr = a; req0_cmd = c;
      end
      #1;
      chk(tag, which ? req1_ready : req0_ready, 1);
      f.addr = a;
      f.cmd  = c;
      sb.push_back(f);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (!(sched_state == 2'd0 && fifo_count == 3'd0) && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_drain"}, (n < budget), 1);
      score(tag);
   endtask

   initial begin
      frame_t f;
      int     n;
      int     cnt;
      int     base;
      int     e0;
      bit     rr_m;
      int     n0;
      int     n1;
      int     exp_cnt [5];

      rst_n = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_cmd = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_cmd = '0;
      xmit_en = 1'b1;
      busy_len = 10;
`ifdef IR_TX_REPEAT_EN
      rep_hold = 1'b0;
`endif

      // reset values
      repeat (3) step();
      chk("rst_tx_send", tx_send, 0);
      chk("rst_tx_addr", tx_addr, 0);
      chk("rst_tx_cmd", tx_cmd, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_state", sched_state, 0);
      rst_n = 1'b1;
      step();

      // single frame latency and handshake with the transmitter
      push1(1'b0, 16'h00FF, 8'h12, "t1_ready");
      chk("t1_count_after_push", fifo_count, 1);
      chk("t1_send_not_yet", tx_send, 0);
      step();
      chk("t1_send", tx_send, 1);
      chk("t1_state_issue", sched_state, 1);
      chk("t1_addr", tx_addr, 16'h00FF);
      chk("t1_cmd", tx_cmd, 8'h12);
      chk("t1_count_popped", fifo_count, 0);
      step();
      chk("t1_send_drop", tx_send, 0);
      chk("t1_state_active", sched_state, 2);
      repeat (9) step();
      chk("t1_still_active", sched_state, 2);
      step();
      chk("t1_state_idle", sched_state, 0);
      chk("t1_count_end", fifo_count, 0);
      score("t1");

      // round-robin with both requesters valid, then full
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      exp_cnt = '{1, 1, 2, 3, 4};
      rr_m = 1'b0;
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 5; k++) begin
         req0_valid = 1'b1; req0_addr = 16'hA000 + 16'(n0); req0_cmd = 8'h10 + 8'(n0);
         req1_valid = 1'b1; req1_addr = 16'hB000 + 16'(n1); req1_cmd = 8'h20 + 8'(n1);
         #1;
         chk("t2_ready0", req0_ready, !rr_m);
         chk("t2_ready1", req1_ready, rr_m);
         if (!rr_m) begin
            f.addr = req0_addr; f.cmd = req0_cmd; n0++;
         end else begin
            f.addr = req1_addr; f.cmd = req1_cmd; n1++;
         end
         sb.push_back(f);
         rr_m = !rr_m;
         step();
         chk("t2_count", fifo_count, exp_cnt[k]);
      end
      req0_addr = 16'hA0FF;
      req1_addr = 16'hB0FF;
      #1;
      chk("t2_full_ready0", req0_ready, 0);
      chk("t2_full_ready1", req1_ready, 0);
      chk("t2_full_count", fifo_count, 4);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_drain("t2", 300);

      // same-edge push/pop at count 2, then pointer wrap over six frames
      push1(1'b0, 16'hC000, 8'h30, "t3_ready0");
      push1(1'b1, 16'hC001, 8'h31, "t3_ready1");
      push1(1'b0, 16'hC002, 8'h32, "t3_ready2");
      n = 0;
      while (sched_state != 2'd0 && n < 50) begin
         step();
         n++;
      end
      chk("t3_reach_idle", (n < 50), 1);
      chk("t3_count_before", fifo_count, 2);
      push1(1'b1, 16'hC003, 8'h33, "t3_ready3");
      chk("t3_count_same_edge", fifo_count, 2);
      chk("t3_send_same_edge", tx_send, 1);
      push1(1'b0, 16'hC004, 8'h34, "t3_ready4");
      push1(1'b1, 16'hC005, 8'h35, "t3_ready5");
      wait_drain("t3", 300);

      // busy never rises: timeout, error pulse, next frame still issued
      xmit_en = 1'b0;
      e0 = err_cnt;
      push1(1'b0, 16'hDEAD, 8'h01, "t4_ready0");
      push1(1'b1, 16'hBEEF, 8'h02, "t4_ready1");
      cnt = 0;
      while (tx_send === 1'b1 && cnt < 3000) begin
         cnt++;
         step();
      end
      xmit_en = 1'b1;
      chk("t4_send_cycles", cnt, TIMEOUT);
      chk("t4_err_pulse", err_timeout, 1);
      chk("t4_state_idle", sched_state, 0);
      chk("t4_count", fifo_count, 1);
      step();
      chk("t4_err_cleared", err_timeout, 0);
      chk("t4_next_send", tx_send, 1);
      chk("t4_next_addr", tx_addr, 16'hBEEF);
      wait_drain("t4", 100);
      chk("t4_err_count", err_cnt - e0, 1);

      // reset during ACTIVE with three frames queued
      busy_len = 30;
      push1(1'b0, 16'hE000, 8'h40, "t5_ready0");
      push1(1'b1, 16'hE001, 8'h41, "t5_ready1");
      push1(1'b0, 16'hE002, 8'h42, "t5_ready2");
      push1(1'b1, 16'hE003, 8'h43, "t5_ready3");
      chk("t5_pre_state", sched_state, 2);
      chk("t5_pre_count", fifo_count, 3);
      score("t5_first");
      rst_n = 1'b0;
      #1;
      chk("t5_rst_send", tx_send, 0);
      chk("t5_rst_state", sched_state, 0);
      chk("t5_rst_count", fifo_count, 0);
      chk("t5_rst_addr", tx_addr, 0);
      chk("t5_rst_cmd", tx_cmd, 0);
      chk("t5_rst_err", err_timeout, 0);
      sb.delete();
      repeat (2) step();
      rst_n = 1'b1;
      base = obs_wr;
      repeat (20) step();
      chk("t5_no_send_after_reset", obs_wr - base, 0);
      chk("t5_idle_after_reset", sched_state, 0);
      busy_len = 10;
      push1(1'b0, 16'hF000, 8'h50, "t5_ready_new");
      wait_drain("t5", 100);

`ifdef IR_TX_REPEAT_EN
      // held-key auto-repeat
      busy_len = 5;
      rep_hold = 1'b1;
      base = obs_wr;
      push1(1'b0, 16'h1234, 8'h56, "t6_ready");
      f.addr = 16'h1234;
      f.cmd  = 8'h56;
      sb.push_back(f);
      sb.push_back(f);
      n = 0;
      while (obs_wr < base + 3 && n < 200) begin
         step();
         n++;
      end
      chk("t6_repeats_seen", (n < 200), 1);
      rep_hold = 1'b0;
      wait_drain("t6", 100);
      repeat (20) step();
      chk("t6_repeat_stopped", obs_wr - base, 3);
      score("t6_tail");
`endif

      score("final");
      chk("no_unexpected_sends", extra, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
